// File: rtl/regfile_wb_arbiter_if.sv
// Register-file write-port bundle: WB writer, multicycle result
// handshake, ID issue/source fields, stall, rf write port, scoreboard.
interface regfile_wb_arbiter_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic                   wb_we;
   logic [AW-1:0]          wb_wn;
   logic [DW-1:0]          wb_d;
   logic                   mu_valid;
   logic [AW-1:0]          mu_wn;
   logic [DW-1:0]          mu_d;
   logic                   mu_ready;
   logic                   iss_valid;
   logic [AW-1:0]          iss_wn;
   logic [AW-1:0]          rs;
   logic [AW-1:0]          rt;
   logic                   stall;
   logic                   rf_we;
   logic [AW-1:0]          rf_wn;
   logic [DW-1:0]          rf_d;
   logic [(1<<AW)-1:0]     busy;

   modport master (
      output wb_we, wb_wn, wb_d,
      output mu_valid, mu_wn, mu_d,
      output iss_valid, iss_wn, rs, rt,
      input  mu_ready, stall,
      input  rf_we, rf_wn, rf_d, busy
   );

   modport slave (
      input  wb_we, wb_wn, wb_d,
      input  mu_valid, mu_wn, mu_d,
      input  iss_valid, iss_wn, rs, rt,
      output mu_ready, stall,
      output rf_we, rf_wn, rf_d, busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter + busy scoreboard for the 32x32 register file.
// Ports: clk, rst (async, active-high), bus (slave side of the
// regfile_wb_arbiter_if: WB write, mu result handshake, ID issue and
// source fields in; stall, rf_we/rf_wn/rf_d, busy out).
module regfile_wb_arbiter #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic                clk,
   input  logic                rst,
   regfile_wb_arbiter_if.slave bus
);
   localparam int NR = 1 << AW;

   logic [AW-1:0] q_wn [2];
   logic [DW-1:0] q_d  [2];
   logic          rd_ptr;
   logic          wr_ptr;
   logic [1:0]    count;

   logic [NR-1:0] busy_q;
   logic [NR-1:0] set_v;
   logic [NR-1:0] clr_v;

   logic          rf_we_q;
   logic [AW-1:0] rf_wn_q;
   logic [DW-1:0] rf_d_q;

   logic          wb_go;
   logic          ready;
   logic          push;
   logic          pop;
   logic [AW-1:0] head_wn;
   logic [DW-1:0] head_d;
   logic          stall_c;

   assign wb_go   = bus.wb_we && (bus.wb_wn != '0);
   assign head_wn = q_wn[rd_ptr];
   assign head_d  = q_d[rd_ptr];
   // Ready comes from the registered count only, so a pop in the
   // same cycle never frees a slot early.
   assign ready   = (count != 2'd2);
   assign push    = bus.mu_valid && ready;
   // WB has absolute priority; an entry for r0 still pops, silently.
   assign pop     = !wb_go && (count != 2'd0);

   always_comb begin
      stall_c = 1'b0;
      if (bus.rs != '0 && busy_q[bus.rs])
         stall_c = 1'b1;
      if (bus.rt != '0 && busy_q[bus.rt])
         stall_c = 1'b1;
      if (bus.iss_valid && busy_q[bus.iss_wn])
         stall_c = 1'b1;
   end

   always_comb begin
      set_v = '0;
      clr_v = '0;
      if (pop && head_wn != '0)
         clr_v[head_wn] = 1'b1;
      if (bus.iss_valid && !stall_c && bus.iss_wn != '0)
         set_v[bus.iss_wn] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we_q <= 1'b0;
         rf_wn_q <= '0;
         rf_d_q  <= '0;
         count   <= 2'd0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         busy_q  <= '0;
      end else begin
         // Set is OR-ed after clear so a same-cycle set wins.
         busy_q <= (busy_q & ~clr_v) | set_v;
         if (wb_go) begin
            rf_we_q <= 1'b1;
            rf_wn_q <= bus.wb_wn;
            rf_d_q  <= bus.wb_d;
         end else if (pop && head_wn != '0) begin
            rf_we_q <= 1'b1;
            rf_wn_q <= head_wn;
            rf_d_q  <= head_d;
         end else begin
            rf_we_q <= 1'b0;
         end
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // FIFO payload needs no reset: reset empties it through count.
   always_ff @(posedge clk) begin
      if (push) begin
         q_wn[wr_ptr] <= bus.mu_wn;
         q_d[wr_ptr]  <= bus.mu_d;
      end
   end

   assign bus.mu_ready = ready;
   assign bus.stall    = stall_c;
   assign bus.rf_we    = rf_we_q;
   assign bus.rf_wn    = rf_wn_q;
   assign bus.rf_d     = rf_d_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table, contention and
// mid-operation reset sequences, and a write-stream scoreboard.
module tb_regfile_wb_arbiter;
   typedef struct {
      logic        wb_we;
      logic [4:0]  wb_wn;
      logic [31:0] wb_d;
      logic        mv;
      logic [4:0]  mwn;
      logic [31:0] md;
      logic        iv;
      logic [4:0]  iwn;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        e_stall;
      logic        e_ready;
      logic        e_we;
      logic [31:0] e_busy;
   } vec_t;

   typedef struct {
      logic [4:0]  wn;
      logic [31:0] d;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   ent_t exp_q[$];
   vec_t tbl[24];

   regfile_wb_arbiter_if #(.DW(32), .AW(5)) bus ();

   regfile_wb_arbiter #(.DW(32), .AW(5)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic vec_t mk(
      logic we, logic [4:0] wn, logic [31:0] d,
      logic mv, logic [4:0] mwn, logic [31:0] md,
      logic iv, logic [4:0] iwn, logic [4:0] rs, logic [4:0] rt,
      logic es, logic er, logic ew, logic [31:0] eb);
      vec_t v;
      v.wb_we = we;  v.wb_wn = wn;  v.wb_d = d;
      v.mv = mv;     v.mwn = mwn;   v.md = md;
      v.iv = iv;     v.iwn = iwn;   v.rs = rs;  v.rt = rt;
      v.e_stall = es; v.e_ready = er; v.e_we = ew; v.e_busy = eb;
      return v;
   endfunction

   task automatic idle();
      bus.wb_we = 1'b0; bus.wb_wn = 5'd0; bus.wb_d = 32'd0;
      bus.mu_valid = 1'b0; bus.mu_wn = 5'd0; bus.mu_d = 32'd0;
      bus.iss_valid = 1'b0; bus.iss_wn = 5'd0;
      bus.rs = 5'd0; bus.rt = 5'd0;
   endtask

   task automatic drive(input vec_t v);
      bus.wb_we = v.wb_we; bus.wb_wn = v.wb_wn; bus.wb_d = v.wb_d;
      bus.mu_valid = v.mv; bus.mu_wn = v.mwn; bus.mu_d = v.md;
      bus.iss_valid = v.iv; bus.iss_wn = v.iwn;
      bus.rs = v.rs; bus.rt = v.rt;
   endtask

   // Scoreboard: accepted multicycle results queue in order; each rf
   // write must be the WB request of the previous cycle or, lacking
   // one, the oldest outstanding multicycle result.
   logic wb_req;
   ent_t wb_ent;
   ent_t got;
   always @(posedge clk) begin
      if (!rst) begin
         wb_req = bus.wb_we && (bus.wb_wn != 5'd0);
         wb_ent.wn = bus.wb_wn;
         wb_ent.d  = bus.wb_d;
         if (bus.mu_valid && bus.mu_ready && bus.mu_wn != 5'd0)
            exp_q.push_back('{bus.mu_wn, bus.mu_d});
         #1;
         if (!rst) begin
            if (wb_req) begin
               chk("sb_wb_we", 32'(bus.rf_we), 32'd1);
               chk("sb_wb_wn", 32'(bus.rf_wn), 32'(wb_ent.wn));
               chk("sb_wb_d", bus.rf_d, wb_ent.d);
            end else if (bus.rf_we) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_extra actual=write r%0d required=none",
                           bus.rf_wn);
               end else begin
                  got = exp_q.pop_front();
                  chk("sb_mu_wn", 32'(bus.rf_wn), 32'(got.wn));
                  chk("sb_mu_d", bus.rf_d, got.d);
               end
            end
         end
      end
   end

   initial begin
      tbl[0]  = mk(1'b1,5'd3,32'h1234, 1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b1,32'h0);
      tbl[1]  = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h0);
      tbl[2]  = mk(1'b1,5'd0,32'h55,   1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h0);
      tbl[3]  = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b1,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h0);
      tbl[4]  = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b1,5'd7, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h80);
      tbl[5]  = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b1,1'b0,32'h80);
      tbl[6]  = mk(1'b0,5'd0,32'h0,    1'b1,5'd7,32'hDEADBEEF, 1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b1,1'b0,32'h80);
      tbl[7]  = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b1,1'b1,32'h0);
      tbl[8]  = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b1,1'b0,32'h0);
      tbl[9]  = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b1,5'd4, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h10);
      tbl[10] = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b1,5'd4, 5'd0,5'd0, 1'b1,1'b1,1'b0,32'h10);
      tbl[11] = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0,5'd4, 1'b1,1'b1,1'b0,32'h10);
      tbl[12] = mk(1'b0,5'd0,32'h0,    1'b1,5'd4,32'h44, 1'b1,5'd4, 5'd0,5'd0, 1'b1,1'b1,1'b0,32'h10);
      tbl[13] = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b1,5'd4, 5'd0,5'd0, 1'b1,1'b1,1'b1,32'h0);
      tbl[14] = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b1,5'd4, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h10);
      tbl[15] = mk(1'b0,5'd0,32'h0,    1'b1,5'd4,32'h45, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h10);
      tbl[16] = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b1,32'h0);
      tbl[17] = mk(1'b0,5'd0,32'h0,    1'b1,5'd0,32'h77, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h0);
      tbl[18] = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h0);
      tbl[19] = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b1,5'd9, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h200);
      tbl[20] = mk(1'b1,5'd9,32'h99,   1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b1,32'h200);
      tbl[21] = mk(1'b0,5'd0,32'h0,    1'b1,5'd9,32'h909, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h200);
      tbl[22] = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b1,32'h0);
      tbl[23] = mk(1'b0,5'd0,32'h0,    1'b0,5'd0,32'd0, 1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0,32'h0);

      rst = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_we", 32'(bus.rf_we), 32'd0);
      chk("rst_wn", 32'(bus.rf_wn), 32'd0);
      chk("rst_d", bus.rf_d, 32'd0);
      chk("rst_busy", bus.busy, 32'd0);
      chk("rst_ready", 32'(bus.mu_ready), 32'd1);
      chk("rst_stall", 32'(bus.stall), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         chk($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(tbl[i].e_stall));
         chk($sformatf("v%0d_ready", i), 32'(bus.mu_ready), 32'(tbl[i].e_ready));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_we", i), 32'(bus.rf_we), 32'(tbl[i].e_we));
         chk($sformatf("v%0d_busy", i), bus.busy, tbl[i].e_busy);
      end

      // Contention: two results queued behind a 3-cycle WB stream.
      @(negedge clk);
      idle();
      bus.mu_valid = 1'b1; bus.mu_wn = 5'd8; bus.mu_d = 32'h8;
      @(negedge clk);
      bus.wb_we = 1'b1; bus.wb_wn = 5'd2; bus.wb_d = 32'h2222;
      bus.mu_wn = 5'd9; bus.mu_d = 32'h9;
      #1;
      chk("ct_ready_b", 32'(bus.mu_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("ct_wn_b", 32'(bus.rf_wn), 32'd2);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         bus.mu_wn = 5'd10; bus.mu_d = 32'hA;
         #1;
         chk($sformatf("ct_full%0d", k), 32'(bus.mu_ready), 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("ct_wb%0d", k), 32'(bus.rf_wn), 32'd2);
      end
      @(negedge clk);
      idle();
      #1;
      chk("ct_full_e", 32'(bus.mu_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("ct_r8_we", 32'(bus.rf_we), 32'd1);
      chk("ct_r8_wn", 32'(bus.rf_wn), 32'd8);
      chk("ct_r8_d", bus.rf_d, 32'h8);
      chk("ct_ready_back", 32'(bus.mu_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("ct_r9_wn", 32'(bus.rf_wn), 32'd9);
      chk("ct_r9_d", bus.rf_d, 32'h9);
      @(posedge clk);
      #1;
      chk("ct_done_we", 32'(bus.rf_we), 32'd0);
      chk("ct_drained", 32'(exp_q.size()), 32'd0);

      // Reset mid-operation with a full FIFO and busy[5] set.
      @(negedge clk);
      bus.iss_valid = 1'b1; bus.iss_wn = 5'd5;
      bus.wb_we = 1'b1; bus.wb_wn = 5'd1; bus.wb_d = 32'h11;
      bus.mu_valid = 1'b1; bus.mu_wn = 5'd5; bus.mu_d = 32'h50;
      @(negedge clk);
      bus.iss_valid = 1'b0; bus.iss_wn = 5'd0;
      bus.wb_d = 32'h12;
      bus.mu_wn = 5'd6; bus.mu_d = 32'h60;
      @(negedge clk);
      idle();
      bus.rs = 5'd5;
      #1;
      chk("pre_ready", 32'(bus.mu_ready), 32'd0);
      chk("pre_stall", 32'(bus.stall), 32'd1);
      chk("pre_we", 32'(bus.rf_we), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_we", 32'(bus.rf_we), 32'd0);
      chk("mid_wn", 32'(bus.rf_wn), 32'd0);
      chk("mid_d", bus.rf_d, 32'd0);
      chk("mid_busy", bus.busy, 32'd0);
      chk("mid_ready", 32'(bus.mu_ready), 32'd1);
      chk("mid_stall", 32'(bus.stall), 32'd0);
      exp_q.delete();
      #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("post_we%0d", k), 32'(bus.rf_we), 32'd0);
         chk($sformatf("post_busy%0d", k), bus.busy, 32'd0);
         chk($sformatf("post_ready%0d", k), 32'(bus.mu_ready), 32'd1);
      end
      chk("end_pending", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
